mac_result_fifo: RTL and testbench
==================================

Name: mac_result_fifo

Overview:
- Downstream stage of the 10x10->20 multiply-accumulate unit. It captures every accumulator result presented on f/valid_out and buffers it in a small FIFO.
- Results are delivered to the consumer over a valid/ready handshake.
- The MAC has no backpressure. The FIFO therefore absorbs bursts, and a sticky overflow flag records any result that had to be dropped.

Parameters:
- OUT_WIDTH, 20, width of one accumulator result (matches MAC OUT_WIDTH).
- DEPTH, 8, number of entries; must be a power of 2, minimum 2.
- CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  rising-edge clock, shared with the MAC.
- reset  input  1  asynchronous, active-low reset: 0 = reset asserted, 1 = run.
- din  input  OUT_WIDTH  signed result from the MAC (driven by MAC f).
- valid_in  input  1  din is a new result this cycle (driven by MAC valid_out).
- dout  output  OUT_WIDTH  signed head-of-FIFO result.
- valid_out  output  1  dout holds a valid result.
- ready_in  input  1  consumer accepts dout this cycle.
- count  output  CNT_WIDTH  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: at least one result has been dropped since reset.

Behaviour:
- Reset (reset == 0, asynchronous):
  - Read and write pointers, count, overflow and valid_out all go to 0.
  - dout goes to 0.
  - Storage contents are don't-care.
- Handshakes, all evaluated at the clock edge:
  - push = valid_in && (!full || pop).
  - pop = valid_out && ready_in.
  - drop = valid_in && full && !pop.
- Storage:
  - DEPTH x OUT_WIDTH register array.
  - Write and read pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Show-ahead output:
  - valid_out = (count != 0).
  - dout = entry at the read pointer.
  - dout must not change while valid_out == 1 and ready_in == 0.
- Latency:
  - A result pushed into an empty FIFO at edge N is visible on dout with valid_out = 1 immediately after edge N.
  - There are no bubbles; back-to-back valid_in every cycle is sustained as long as the consumer keeps ready_in = 1.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Full with simultaneous pop: the push is accepted and no drop occurs.
- Empty with valid_in:
  - ready_in has no effect because valid_out == 0.
  - No pass-through in the same cycle.
- Overflow:
  - On drop, din is discarded, storage and pointers are unchanged, and overflow is set to 1.
  - overflow stays 1 until reset; there is no other clear path.
- Arithmetic: din is stored bit-exact; no sign extension, saturation or modification.
- Reset mid-operation:
  - All buffered results are lost and count returns to 0.
  - The first valid_in after reset is released is the first result delivered.
- ready_in while empty: ignored; pointers and count are unchanged.

Test Plan:
1. Single pass: reset, then push din = 20'sd12345 with ready_in = 0.
   - Next cycle: valid_out = 1, dout = 12345, count = 1.
   - Then raise ready_in for one cycle: count = 0, valid_out = 0.
2. Fill and hold: DEPTH = 8, ready_in = 0, push values -4, -3, ..., 3.
   - After 8 pushes: full = 1, count = 8, dout = -4, overflow = 0.
   - Draining with ready_in = 1 returns -4, -3, ..., 3 in order.
3. Overflow: fill 8 entries, then push 999 with ready_in = 0.
   - Required: overflow = 1, count stays 8, and 999 is never output.
   - overflow remains 1 after draining, and clears only on reset == 0.
4. Full with simultaneous pop: fill 8 entries, then assert valid_in (din = 777) and ready_in in the same cycle.
   - Required: count stays 8, overflow = 0.
   - 777 is output last, after 7 further pops.
5. Streaming and wrap-around: 40 consecutive pushes (values 1..40) with ready_in held at 1.
   - Required: dout follows the sequence 1..40 one cycle behind, count never exceeds 1.
   - Pointers wrap 5 times with no loss.
6. Asynchronous reset: load 5 entries, then drive reset = 0 mid-cycle, away from the clock edge.
   - Required: valid_out = 0, count = 0, dout = 0 immediately, without waiting for an edge.
   - After release, pushing 42 delivers 42 first.

Source files
------------

// File: rtl/mac_result_fifo_if.sv
// Result bus between the MAC result FIFO and its neighbours.
// Carries the MAC-side write (din/valid_in), the consumer-side read
// (dout/valid_out/ready_in) and the status outputs (count/full/overflow).
// slave  : the FIFO itself.
// master : the environment around it (MAC producer plus consumer).
// Data fields are plain bit vectors. The consumer interprets them as signed
// two's complement; the FIFO stores and returns them bit-exact.
interface mac_result_fifo_if #(
  parameter int OUT_WIDTH = 20,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
);
  logic [OUT_WIDTH-1:0] din;
  logic                 valid_in;
  logic [OUT_WIDTH-1:0] dout;
  logic                 valid_out;
  logic                 ready_in;
  logic [CNT_WIDTH-1:0] count;
  logic                 full;
  logic                 overflow;

  modport slave (
    input  din, valid_in, ready_in,
    output dout, valid_out, count, full, overflow
  );

  modport master (
    output din, valid_in, ready_in,
    input  dout, valid_out, count, full, overflow
  );
endinterface

// File: rtl/mac_result_fifo.sv
// Purpose: buffers MAC accumulator results in a show-ahead FIFO and sets a sticky overflow flag.
// Latency: a result written into an empty FIFO is on dout with valid_out=1 right after the write edge.
// Backpressure: the consumer stalls with ready_in; the MAC cannot be stalled, so writes to a full FIFO are dropped.
// Ports: clk, reset (async, active-low), bus (mac_result_fifo_if.slave):
//   din/valid_in from the MAC, dout/valid_out/ready_in to the consumer,
//   count/full/overflow as status.
// DEPTH must be a power of two (at least 2) so the pointers wrap naturally.
module mac_result_fifo #(
  parameter int OUT_WIDTH = 20,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  mac_result_fifo_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);

  logic [OUT_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 overflow_q;

  logic full_w;
  logic valid_w;
  logic push;
  logic pop;
  logic drop;

  assign full_w  = (count_q == DEPTH_CNT);
  assign valid_w = (count_q != '0);

  // A pop frees a slot in the same edge, so a full FIFO still accepts a
  // write when the consumer is reading. ready_in is ignored when empty.
  assign pop  = valid_w && bus.ready_in;
  assign push = bus.valid_in && (!full_w || pop);
  assign drop = bus.valid_in && full_w && !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      // Sticky: only reset clears it.
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Storage has no reset. Its contents are never observed while the FIFO
  // is empty because of the dout gating below.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.din;
  end

  // Show-ahead head. Gating with valid_w forces dout to 0 as soon as reset
  // asserts, without waiting for an edge and without clearing the array.
  // The head slot cannot be overwritten while it is occupied, so dout holds
  // steady during a stall.
  assign bus.dout      = valid_w ? mem[rd_ptr] : '0;
  assign bus.valid_out = valid_w;
  assign bus.count     = count_q;
  assign bus.full      = full_w;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_mac_result_fifo.sv
// Bench for mac_result_fifo: directed stimulus plus an expected-result queue.
// The stimulus pushes every accepted result into exp_q. A negedge monitor pops
// and compares on each handshake, and also checks that dout holds during stalls.
module tb_mac_result_fifo;
  localparam int W  = 20;
  localparam int D  = 8;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mac_result_fifo_if #(.OUT_WIDTH(W), .DEPTH(D), .CNT_WIDTH(CW)) bus ();

  mac_result_fifo #(.OUT_WIDTH(W), .DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q [$];
  bit           hold_prev = 1'b0;
  logic [W-1:0] dout_prev = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: an output handshake completes at the next posedge.
  always @(negedge clk) begin
    if (!reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && bus.valid_out) check("dout_hold", 32'(bus.dout), 32'(dout_prev));
      if (bus.valid_out && bus.ready_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0d with no result expected", bus.dout);
        end else begin
          check("dout", 32'(bus.dout), 32'(exp_q.pop_front()));
        end
      end
      hold_prev = bus.valid_out && !bus.ready_in;
      dout_prev = bus.dout;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] v, input bit accept);
    bus.din      = v;
    bus.valid_in = 1'b1;
    if (accept) exp_q.push_back(v);
    tick();
    bus.valid_in = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    bus.ready_in = 1'b1;
    for (int i = 0; i < 4 * D && !done; i++) begin
      tick();
      if (!bus.valid_out) done = 1'b1;
    end
    bus.ready_in = 1'b0;
    check({name, "_drained"}, 32'(done), 32'd1);
  endtask

  // Entered 1 time unit after a posedge. The reset pulse straddles a negedge
  // and avoids both clock edges.
  task automatic pulse_reset();
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset        = 1'b0;
    bus.din      = '0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;

    #17;
    check("rst_valid_out", 32'(bus.valid_out), 32'd0);
    check("rst_count",     32'(bus.count),     32'd0);
    check("rst_full",      32'(bus.full),      32'd0);
    check("rst_overflow",  32'(bus.overflow),  32'd0);
    check("rst_dout",      32'(bus.dout),      32'd0);
    #6;
    reset = 1'b1;
    tick();

    // 1. Single pass.
    push(20'd12345, 1'b1);
    check("t1_valid_out", 32'(bus.valid_out), 32'd1);
    check("t1_dout",      32'(bus.dout),      32'd12345);
    check("t1_count",     32'(bus.count),     32'd1);
    bus.ready_in = 1'b1;
    tick();
    bus.ready_in = 1'b0;
    check("t1_count_after_pop", 32'(bus.count),     32'd0);
    check("t1_valid_after_pop", 32'(bus.valid_out), 32'd0);

    // 2. Fill with -4..3 and hold, then drain in order.
    for (int i = -4; i < 4; i++) push(W'(i), 1'b1);
    check("t2_full",     32'(bus.full),     32'd1);
    check("t2_count",    32'(bus.count),    32'd8);
    check("t2_head",     32'(bus.dout),     32'h000FFFFC);  // -4 in 20 bits
    check("t2_overflow", 32'(bus.overflow), 32'd0);
    drain("t2");

    // 3. Overflow: the ninth write is dropped and never appears.
    for (int i = 0; i < D; i++) push(W'(100 + i), 1'b1);
    push(20'd999, 1'b0);
    check("t3_overflow",  32'(bus.overflow), 32'd1);
    check("t3_count",     32'(bus.count),    32'd8);
    check("t3_head",      32'(bus.dout),     32'd100);
    drain("t3");
    check("t3_overflow_sticky", 32'(bus.overflow), 32'd1);
    pulse_reset();
    release_reset();
    check("t3_overflow_cleared", 32'(bus.overflow), 32'd0);

    // 4. Full with a simultaneous pop: the write is accepted.
    for (int i = 0; i < D; i++) push(W'(200 + i), 1'b1);
    bus.ready_in = 1'b1;
    push(20'd777, 1'b1);
    bus.ready_in = 1'b0;
    check("t4_count",    32'(bus.count),    32'd8);
    check("t4_full",     32'(bus.full),     32'd1);
    check("t4_overflow", 32'(bus.overflow), 32'd0);
    check("t4_head",     32'(bus.dout),     32'd201);
    drain("t4");

    // 5. Streaming 1..40 with the consumer always ready.
    bus.ready_in = 1'b1;
    for (int v = 1; v <= 40; v++) begin
      push(W'(v), 1'b1);
      check("t5_count_le1", 32'(bus.count <= CW'(1)), 32'd1);
      check("t5_dout",      32'(bus.dout),            32'(v));
    end
    tick();
    bus.ready_in = 1'b0;
    check("t5_count_end", 32'(bus.count),    32'd0);
    check("t5_overflow",  32'(bus.overflow), 32'd0);

    // 6. Asynchronous reset with 5 entries buffered.
    for (int i = 0; i < 5; i++) push(W'(300 + i), 1'b1);
    check("t6_count_loaded", 32'(bus.count), 32'd5);
    pulse_reset();
    check("t6_async_valid", 32'(bus.valid_out), 32'd0);
    check("t6_async_count", 32'(bus.count),     32'd0);
    check("t6_async_dout",  32'(bus.dout),      32'd0);
    release_reset();
    push(20'd42, 1'b1);
    check("t6_first_dout",  32'(bus.dout),  32'd42);
    check("t6_first_count", 32'(bus.count), 32'd1);
    drain("t6");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
